// File: rtl/branch_cond_unit_if.sv
// Decode-stage branch bundle between the control unit/ID stage and branch_cond_unit.
// master drives the ID/EX decode inputs; slave is the branch unit itself.
interface branch_cond_unit_if;
    logic [31:0] ID_Instr;
    logic [7:0]  ID_PC;
    logic        ID_B_instr;
    logic        ID_29_a;
    logic        EX_modifyCC;
    logic [3:0]  EX_flags;
    logic [3:0]  icc;
    logic        branch_taken;
    logic [7:0]  target_addr;
    logic        squash_ID;
    logic        cc_stall;

    modport master (
        output ID_Instr, ID_PC, ID_B_instr, ID_29_a, EX_modifyCC, EX_flags,
        input  icc, branch_taken, target_addr, squash_ID, cc_stall
    );

    modport slave (
        input  ID_Instr, ID_PC, ID_B_instr, ID_29_a, EX_modifyCC, EX_flags,
        output icc, branch_taken, target_addr, squash_ID, cc_stall
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Bicc resolution in ID: icc register, condition evaluation, target, delay-slot annul FSM.
// Define CC_BYPASS_EN to forward EX_flags into evaluation instead of stalling.
module branch_cond_unit (
    input logic               Clk,
    input logic               R,
    branch_cond_unit_if.slave bcu
);
    typedef enum logic {StRun, StAnnul} state_e;

    state_e      state_q, state_d;
    logic [3:0]  icc_q;
    logic [3:0]  f;
    logic [3:0]  cond;
    logic [21:0] disp22;
    logic        flag_n, flag_z, flag_v, flag_c;
    logic        cond_base;
    logic        cond_true;
    logic        squash;
    logic        stall;
    logic        valid_br;
    logic        annul;
    logic        unused_bits;

    assign cond   = bcu.ID_Instr[28:25];
    assign disp22 = bcu.ID_Instr[21:0];
    assign squash = (state_q == StAnnul);

    // Only the low 8 bits of the scaled displacement can reach an 8-bit PC.
    assign unused_bits = ^{bcu.ID_Instr[31:29], bcu.ID_Instr[24:22], disp22[21:6]};

    assign bcu.target_addr = bcu.ID_PC + {disp22[5:0], 2'b00};

`ifdef CC_BYPASS_EN
    assign f     = bcu.EX_modifyCC ? bcu.EX_flags : icc_q;
    assign stall = 1'b0;
`else
    assign f     = icc_q;
    assign stall = bcu.ID_B_instr & bcu.EX_modifyCC & ~squash;
`endif

    assign {flag_n, flag_z, flag_v, flag_c} = f;

    // cond[3] inverts the base test; base 000 is "never", so 1000 becomes "always".
    always_comb begin
        cond_base = 1'b0;
        unique case (cond[2:0])
            3'b000: cond_base = 1'b0;
            3'b001: cond_base = flag_z;
            3'b010: cond_base = flag_z | (flag_n ^ flag_v);
            3'b011: cond_base = flag_n ^ flag_v;
            3'b100: cond_base = flag_c | flag_z;
            3'b101: cond_base = flag_c;
            3'b110: cond_base = flag_n;
            3'b111: cond_base = flag_v;
            default: cond_base = 1'b0;
        endcase
    end

    assign cond_true = cond_base ^ cond[3];
    assign valid_br  = bcu.ID_B_instr & ~squash & ~stall;
    assign annul     = valid_br & bcu.ID_29_a & (~cond_true | (cond == 4'b1000));

    assign bcu.branch_taken = valid_br & cond_true;
    assign bcu.squash_ID    = squash;
    assign bcu.cc_stall     = stall;
    assign bcu.icc          = icc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   state_d = annul ? StAnnul : StRun;
            StAnnul: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_q <= StRun;
            icc_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (bcu.EX_modifyCC) begin
                icc_q <= bcu.EX_flags;
            end
        end
    end
endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed-vector bench for branch_cond_unit; expectations hand-computed per step.
module tb_branch_cond_unit;
    logic Clk;
    logic R;
    int   total;
    int   bad;

    branch_cond_unit_if bus ();

    branch_cond_unit dut (
        .Clk (Clk),
        .R   (R),
        .bcu (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic a,
                                       input logic [21:0] disp);
        return {2'b00, a, cond, 3'b010, disp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic b, input logic [3:0] cond, input logic a,
                          input logic [7:0] pc, input logic [21:0] disp);
        bus.ID_B_instr = b;
        bus.ID_29_a    = a;
        bus.ID_PC      = pc;
        bus.ID_Instr   = mk(cond, a, disp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        R     = 1'b1;
        bus.EX_modifyCC = 1'b0;
        bus.EX_flags    = 4'b0000;
        set_br(1'b0, 4'b0000, 1'b0, 8'h00, 22'h0);
        #3;
        chk("reset_icc", {28'd0, bus.icc}, 32'h0);
        chk("reset_squash", {31'd0, bus.squash_ID}, 32'h0);
        chk("reset_stall", {31'd0, bus.cc_stall}, 32'h0);
        chk("reset_taken", {31'd0, bus.branch_taken}, 32'h0);
        @(negedge Clk);
        R = 1'b0;

        // Target arithmetic and wrap
        set_br(1'b0, 4'b1000, 1'b0, 8'hF8, 22'h000004);
        #1;
        chk("target_wrap_fwd", {24'd0, bus.target_addr}, 32'h08);
        chk("no_bicc_not_taken", {31'd0, bus.branch_taken}, 32'h0);
        set_br(1'b0, 4'b1000, 1'b0, 8'hF8, 22'h3FFFFE);
        #1;
        chk("target_back", {24'd0, bus.target_addr}, 32'hF0);

        // subcc in EX together with BE in ID
        @(negedge Clk);
        bus.EX_modifyCC = 1'b1;
        bus.EX_flags    = 4'b0100;
        set_br(1'b1, 4'b0001, 1'b0, 8'h10, 22'h000002);
        #1;
        chk("be_target", {24'd0, bus.target_addr}, 32'h18);
`ifdef CC_BYPASS_EN
        chk("bypass_stall", {31'd0, bus.cc_stall}, 32'h0);
        chk("bypass_taken", {31'd0, bus.branch_taken}, 32'h1);
`else
        chk("cc_stall_on", {31'd0, bus.cc_stall}, 32'h1);
        chk("stall_not_taken", {31'd0, bus.branch_taken}, 32'h0);
`endif
        @(negedge Clk);
        bus.EX_modifyCC = 1'b0;
        #1;
        chk("icc_updated", {28'd0, bus.icc}, 32'h4);
        chk("cc_stall_off", {31'd0, bus.cc_stall}, 32'h0);
        chk("be_taken_after", {31'd0, bus.branch_taken}, 32'h1);
        @(negedge Clk);
        chk("be_a0_no_squash", {31'd0, bus.squash_ID}, 32'h0);

        // Clear icc
        set_br(1'b0, 4'b0000, 1'b0, 8'h20, 22'h0);
        bus.EX_modifyCC = 1'b1;
        bus.EX_flags    = 4'b0000;
        @(negedge Clk);
        bus.EX_modifyCC = 1'b0;
        chk("icc_cleared", {28'd0, bus.icc}, 32'h0);

        // BE,a not taken -> annul; BNE,a in the annulled slot is squashed
        set_br(1'b1, 4'b0001, 1'b1, 8'h20, 22'h000008);
        #1;
        chk("be_a_not_taken", {31'd0, bus.branch_taken}, 32'h0);
        chk("be_a_squash_pre", {31'd0, bus.squash_ID}, 32'h0);
        @(negedge Clk);
        set_br(1'b1, 4'b1001, 1'b1, 8'h21, 22'h000008);
        #1;
        chk("annul_squash_on", {31'd0, bus.squash_ID}, 32'h1);
        chk("slot_bne_not_taken", {31'd0, bus.branch_taken}, 32'h0);
        @(negedge Clk);
        set_br(1'b0, 4'b0000, 1'b0, 8'h22, 22'h0);
        chk("annul_one_cycle", {31'd0, bus.squash_ID}, 32'h0);

        // BN,a in slot: would annul if valid, must not start a new ANNUL
        set_br(1'b1, 4'b0001, 1'b1, 8'h30, 22'h0);
        @(negedge Clk);
        set_br(1'b1, 4'b0000, 1'b1, 8'h31, 22'h0);
        @(negedge Clk);
        set_br(1'b0, 4'b0000, 1'b0, 8'h32, 22'h0);
        chk("slot_bn_a_no_annul", {31'd0, bus.squash_ID}, 32'h0);

        // BA,a: taken and annulled; BA without a: taken, no squash
        set_br(1'b1, 4'b1000, 1'b1, 8'h40, 22'h000010);
        #1;
        chk("ba_a_taken", {31'd0, bus.branch_taken}, 32'h1);
        chk("ba_a_target", {24'd0, bus.target_addr}, 32'h80);
        @(negedge Clk);
        set_br(1'b0, 4'b0000, 1'b0, 8'h41, 22'h0);
        chk("ba_a_squash", {31'd0, bus.squash_ID}, 32'h1);
        @(negedge Clk);
        chk("ba_a_squash_off", {31'd0, bus.squash_ID}, 32'h0);
        set_br(1'b1, 4'b1000, 1'b0, 8'h50, 22'h0);
        #1;
        chk("ba_taken", {31'd0, bus.branch_taken}, 32'h1);
        @(negedge Clk);
        set_br(1'b0, 4'b0000, 1'b0, 8'h51, 22'h0);
        chk("ba_no_squash", {31'd0, bus.squash_ID}, 32'h0);

        // Load icc=1111, then BNE,a (not taken, Z=1) to enter ANNUL, reset mid-cycle
        bus.EX_modifyCC = 1'b1;
        bus.EX_flags    = 4'b1111;
        @(negedge Clk);
        bus.EX_modifyCC = 1'b0;
        chk("icc_all_ones", {28'd0, bus.icc}, 32'hF);
        set_br(1'b1, 4'b1001, 1'b1, 8'h60, 22'h0);
        #1;
        chk("bne_a_not_taken", {31'd0, bus.branch_taken}, 32'h0);
        @(posedge Clk);
        #1;
        set_br(1'b0, 4'b0000, 1'b0, 8'h61, 22'h0);
        chk("pre_reset_squash", {31'd0, bus.squash_ID}, 32'h1);
        #1;
        R = 1'b1;
        #1;
        chk("mid_reset_icc", {28'd0, bus.icc}, 32'h0);
        chk("mid_reset_squash", {31'd0, bus.squash_ID}, 32'h0);
        @(negedge Clk);
        R = 1'b0;
        set_br(1'b1, 4'b0001, 1'b0, 8'h70, 22'h0);
        #1;
        chk("post_reset_be", {31'd0, bus.branch_taken}, 32'h0);
        @(negedge Clk);
        set_br(1'b0, 4'b0000, 1'b0, 8'h71, 22'h0);
        chk("post_reset_no_squash", {31'd0, bus.squash_ID}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Decode-stage branch resolution block for the 8-bit-PC SPARC-subset pipeline.
- Holds the integer condition codes (icc).
- Evaluates Bicc conditions for the instruction in ID and computes the branch target.
- Produces the taken-select for the PC/nPC path.
- Drives the delay-slot annul (squash) that forces the ID control-signal mux to NOP.

It sits beside the control unit in ID, consuming its branch/annul decode and the EX stage's flag results.

## Interface
Parameters:
- none (PC width fixed at 8, instruction width fixed at 32)

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- R  in  1  reset, asynchronous, active-high
- ID_Instr  in  32  instruction in ID; cond = [28:25], disp22 = [21:0]
- ID_PC  in  8  PC of the instruction in ID
- ID_B_instr  in  1  control unit: ID holds a Bicc
- ID_29_a  in  1  control unit: annul bit of the Bicc
- EX_modifyCC  in  1  EX instruction writes icc this cycle
- EX_flags  in  4  {N,Z,V,C} produced by the ALU in EX
- icc  out  4  registered {N,Z,V,C}
- branch_taken  out  1  selects target_addr into nPC (combinational)
- target_addr  out  8  branch target
- squash_ID  out  1  registered; drives the control-signal mux select so the instruction in ID becomes a NOP
- cc_stall  out  1  hold PC, nPC and IF/ID and insert a NOP; constant 0 when CC_BYPASS_EN is defined

## Operation
- target_addr = ID_PC + {sign-extended disp22, 2'b00}, truncated to 8 bits (wraps modulo 256).
- Effective flags `f`:
  - EX_flags when EX_modifyCC=1 and CC_BYPASS_EN is defined.
  - Otherwise icc.
- Condition encodings, `cond` = ID_Instr[28:25] (per flags `f`):
  - 1000 always, 0000 never
  - 0001 Z, 1001 !Z
  - 0010 Z|(N^V), 1010 !(Z|(N^V))
  - 0011 N^V, 1011 !(N^V)
  - 0100 C|Z, 1100 !(C|Z)
  - 0101 C, 1101 !C
  - 0110 N, 1110 !N
  - 0111 V, 1111 !V
- branch_taken = ID_B_instr & cond_true & !squash_ID & !cc_stall.
- Annul decision, evaluated for a valid branch (ID_B_instr & !squash_ID & !cc_stall):
  - Annul if a=1 and the branch is not taken.
  - Annul if a=1 and cond=1000 (BA,a).
  - Otherwise the delay slot executes.
- FSM, 2 states:
  - RUN: squash_ID=0. Move to ANNUL when the annul decision is true, else stay in RUN.
  - ANNUL: squash_ID=1 for exactly one cycle, which nullifies the delay slot now in ID. Always returns to RUN.
  - A Bicc sitting in ID during ANNUL is itself squashed: it is neither taken nor able to start a new annul.
- icc: on a rising edge with EX_modifyCC=1, icc <= EX_flags; otherwise icc holds.

## Timing
- Reset (R=1, asynchronous): icc=4'b0000, state=RUN, squash_ID=0. Combinational outputs follow from these values.
- Reset mid-ANNUL returns to RUN immediately, with no squash after release.
- branch_taken and target_addr: combinational, valid in the same cycle the branch is in ID. nPC loads the target at the next edge.
- squash_ID rises on the edge after the annulling branch leaves ID, and falls one cycle later.
- icc latency: visible one edge after the flag-setting instruction is in EX.
- A simultaneous EX_modifyCC and Bicc in ID is resolved using the flags being written (bypass), or by a stall (no bypass).
- cc_stall (without macro) is combinational: ID_B_instr & EX_modifyCC & !squash_ID. It lasts exactly one cycle, because the bubble then occupies EX.

## Configuration
- CC_BYPASS_EN defined:
  - EX_flags are forwarded into condition evaluation.
  - cc_stall is tied to 0.
  - Back-to-back subcc/Bicc costs no cycles.
- CC_BYPASS_EN undefined:
  - Evaluation uses icc only.
  - A Bicc behind a CC-modifying instruction raises cc_stall for one cycle, then evaluates against the updated icc.

## Test plan
- Reset value: assert R mid-cycle with icc=4'b1111 in ANNUL -> icc=0000, squash_ID=0 immediately; BE then not taken.
- Target arithmetic and wrap: ID_PC=8'hF8, disp22=22'h000004 -> target_addr=8'h08. disp22=22'h3FFFFE -> target_addr=8'hF0.
- CC update and conditional branch: EX_modifyCC=1 with EX_flags=0100, then BE in ID.
  - With macro: taken in the same cycle.
  - Without macro: cc_stall=1 for one cycle, then taken with icc=0100.
- Annul untaken: icc=0000, BE with a=1 -> branch_taken=0; squash_ID=1 for exactly the next cycle, then 0.
- BA,a: cond=1000, a=1 -> branch_taken=1 and squash_ID=1 next cycle. The same with a=0 gives taken and no squash.
- Branch in annulled slot: a BNE (would be taken) arrives in ID while squash_ID=1 -> branch_taken=0, no new ANNUL, state returns to RUN.
